// File: rtl/ahb_lite_interconnect.sv
// ahb_lite_interconnect
//   Single-master AHB-Lite address decoder and response multiplexer with a
//   default (error) slave and a per-data-phase wait timeout.
//
// Ports
//   HCLK, HRESET       clock, asynchronous active-high reset
//   HADDR, HTRANS      master address phase
//   HRDATA, HREADY,    data-phase response to the master; HREADY is also
//   HRESP              broadcast to every slave
//   S_HSEL             one-hot slave select (address phase, combinational)
//   S_HRDATA,          packed per-slave responses, slave 0 in the LSBs
//   S_HREADYOUT,
//   S_HRESP
//   TIMEOUT_EVT        one-cycle pulse in the first ERR1 cycle of a timeout abort
//
// HWRITE, HSIZE and HWDATA are not routed here; the top level broadcasts them.
module ahb_lite_interconnect #(
    parameter int NSLV    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter logic [NSLV*ADDR_W-1:0] BASE =
        {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NSLV*ADDR_W-1:0] MASK = {4{32'hFFFF_0000}},
    parameter int TIMEOUT = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [ADDR_W-1:0]      HADDR,
    input  logic [1:0]             HTRANS,
    output logic [DATA_W-1:0]      HRDATA,
    output logic                   HREADY,
    output logic                   HRESP,
    output logic [NSLV-1:0]        S_HSEL,
    input  logic [NSLV*DATA_W-1:0] S_HRDATA,
    input  logic [NSLV-1:0]        S_HREADYOUT,
    input  logic [NSLV-1:0]        S_HRESP,
    output logic                   TIMEOUT_EVT
);

    localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SLAVE, ERR1, ERR2} state_t;

    state_t            state, nstate;
    logic [SEL_W-1:0]  sel;
    logic [CNT_W-1:0]  cnt;
    logic [NSLV-1:0]   hit;
    logic [SEL_W-1:0]  hit_idx;
    logic              any_hit;
    logic              capture;
    logic              timeout;
    logic              sel_rdy;

    // Region decode
    for (genvar i = 0; i < NSLV; i++) begin : g_dec
        assign hit[i] = (HADDR & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W];
    end

    // Lowest index wins: scan downward so the last assignment is the lowest hit
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = SEL_W'(i);
                any_hit = 1'b1;
            end
        end
    end

    // Select is gated in ERR1 (no accept there) and during reset
    always_comb begin
        S_HSEL = '0;
        if (any_hit && HTRANS[1] && state != ERR1 && !HRESET)
            S_HSEL[hit_idx] = 1'b1;
    end

    assign sel_rdy = S_HREADYOUT[sel];

    // Response mux; slaves are only looked at in SLAVE, so an aborted slave
    // is ignored from ERR1 onward
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        case (state)
            SLAVE: begin
                HRDATA = S_HRDATA[sel*DATA_W +: DATA_W];
                HREADY = sel_rdy;
                HRESP  = S_HRESP[sel];
            end
            ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            ERR2:    HRESP = 1'b1;
            default: ;
        endcase
    end

    assign capture = HREADY && HTRANS[1];
    // A slave that becomes ready on the limit cycle completes normally
    assign timeout = (TIMEOUT != 0) && (state == SLAVE) && !sel_rdy && (cnt == CNT_LIM);

    always_comb begin
        nstate = state;
        case (state)
            ERR1: nstate = ERR2;
            default: begin
                if (timeout)
                    nstate = ERR1;
                else if (HREADY)
                    nstate = !HTRANS[1] ? IDLE : (any_hit ? SLAVE : ERR1);
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= IDLE;
            sel         <= '0;
            cnt         <= '0;
            TIMEOUT_EVT <= 1'b0;
        end else begin
            state       <= nstate;
            TIMEOUT_EVT <= timeout;
            if (capture) begin
                cnt <= '0;
                if (any_hit)
                    sel <= hit_idx;
            end else if (state == SLAVE && !sel_rdy && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
